multicycle_controller: RTL

Control FSM that sequences the shared RISC-V datapath over multiple cycles (fetch, decode, execute, memory, writeback) in place of single-cycle combinational control. One ALU and one unified memory port are reused across cycles. The block drives every datapath mux and enable. It stalls on a memory ready handshake and pulses `instr_done` once per retired instruction.

---
 rtl/riscv_multi_pkg.sv | 79 +++++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_multi_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, funct3 values and every datapath mux/ALU select encoding.
// Pure declarations; no logic, no latency, no flow control.
package riscv_multi_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    // Major opcodes handled by the sequencer
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values used by the ALU decoder and branch evaluation
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operand sources
    localparam logic [1:0] ASEL_PC    = 2'b00;
    localparam logic [1:0] ASEL_OLDPC = 2'b01;
    localparam logic [1:0] ASEL_RS1   = 2'b10;
    localparam logic [1:0] BSEL_RS2   = 2'b00;
    localparam logic [1:0] BSEL_XIMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR  = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; I-format for anything without
    // a dedicated encoding so loads and I-type ALU ops fall out naturally.
    function automatic logic [1:0] imm_sel_from_opcode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 and the R-type flag onto the ALU operation select.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module alu_decoder
    import riscv_multi_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       rtype_i,
    output logic [2:0] alu_control_o
);

    // funct3 selects the operation; only R-type may turn add into sub
    always_comb begin
        alu_control_o = ALU_ADD;
        case (funct3_i)
            F3_ADD:  alu_control_o = (rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            F3_SLT:  alu_control_o = ALU_SLT;
            F3_XOR:  alu_control_o = ALU_XOR;
            F3_OR:   alu_control_o = ALU_OR;
            F3_AND:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM driving every shared-datapath mux and enable.
// Latency: branch 3, R/I/store/jal 4, load 5 cycles, +1 per mem_ready=0 wait.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu.
module multicycle_controller
    import riscv_multi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       adr_sel,
    output logic       IR_write,
    output logic       mem_write,
    output logic       regfile_wren,
    output logic [1:0] result_sel,
    output logic [1:0] ALU_asel,
    output logic [1:0] ALU_bsel,
    output logic [1:0] ximm_sel,
    output logic [2:0] ALU_control,
    output logic       instr_done
);

    state_t     state_q, state_d;
    logic       is_rtype;
    logic [2:0] dec_alu_control;
    logic       branch_taken;

    // Strobes before reset gating
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       rf_wren_raw;
    logic       done_raw;

    assign is_rtype = (opcode == OP_RTYPE);

    alu_decoder u_alu_decoder (
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .rtype_i       (is_rtype),
        .alu_control_o (dec_alu_control)
    );

`ifdef BRANCH_EXT_EN
    // Full conditional-branch set evaluated from the subtract flags
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = Z;
            F3_BNE:  branch_taken = ~Z;
            F3_BLT:  branch_taken = N ^ V;
            F3_BGE:  branch_taken = ~(N ^ V);
            F3_BLTU: branch_taken = ~C;
            F3_BGEU: branch_taken = C;
            default: branch_taken = 1'b0;
        endcase
    end
`else
    // Only beq is supported; N/C/V have no consumer in this build
    logic unused_flags;
    assign unused_flags = ^{N, C, V};
    assign branch_taken = (funct3 == F3_BEQ) & Z;
`endif

    // State register; reset parks the sequencer at FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing, holding in the memory states until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath control decode; unlisted outputs stay at 0
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        rf_wren_raw   = 1'b0;
        done_raw      = 1'b0;
        adr_sel       = 1'b0;
        result_sel    = RES_ALUOUT;
        ALU_asel      = ASEL_PC;
        ALU_bsel      = BSEL_RS2;
        ximm_sel      = IMM_I;
        ALU_control   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU to PC as the word arrives
                ALU_bsel     = BSEL_FOUR;
                result_sel   = RES_ALURES;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                // Branch/jump target lands in ALU_out for later states
                ALU_asel = ASEL_OLDPC;
                ALU_bsel = BSEL_XIMM;
                ximm_sel = imm_sel_from_opcode(opcode);
            end
            S_MEMADR: begin
                ALU_asel = ASEL_RS1;
                ALU_bsel = BSEL_XIMM;
                ximm_sel = imm_sel_from_opcode(opcode);
            end
            S_MEMREAD: begin
                adr_sel = 1'b1;
            end
            S_MEMWB: begin
                result_sel  = RES_DATA;
                rf_wren_raw = 1'b1;
                done_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_sel       = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_ready;
            end
            S_EXECUTER: begin
                ALU_asel    = ASEL_RS1;
                ALU_bsel    = BSEL_RS2;
                ALU_control = dec_alu_control;
            end
            S_EXECUTEI: begin
                ALU_asel    = ASEL_RS1;
                ALU_bsel    = BSEL_XIMM;
                ximm_sel    = IMM_I;
                ALU_control = dec_alu_control;
            end
            S_ALUWB: begin
                result_sel  = RES_ALUOUT;
                rf_wren_raw = 1'b1;
                done_raw    = 1'b1;
            end
            S_JAL: begin
                // Target from DECODE loads PC while the ALU forms the link value
                ALU_asel     = ASEL_OLDPC;
                ALU_bsel     = BSEL_FOUR;
                result_sel   = RES_ALUOUT;
                pc_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALU_asel     = ASEL_RS1;
                ALU_bsel     = BSEL_RS2;
                ALU_control  = ALU_SUB;
                result_sel   = RES_ALUOUT;
                pc_write_raw = branch_taken;
                done_raw     = 1'b1;
            end
            default: begin
                ALU_bsel   = BSEL_FOUR;
                result_sel = RES_ALURES;
            end
        endcase
    end

    // Reset gates every strobe combinationally so none survives assertion
    assign PC_write     = pc_write_raw  & reset;
    assign IR_write     = ir_write_raw  & reset;
    assign mem_write    = mem_write_raw & reset;
    assign regfile_wren = rf_wren_raw   & reset;
    assign instr_done   = done_raw      & reset;

endmodule
